// File: rtl/sec_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : sec_reg_bank
// Purpose  : Secure register bank with per-register lock/read/write
//            permissions, denied-access counting and sticky lockdown alert.
// Revision : 1.0
// ============================================================================
module sec_reg_bank #(
   parameter int DW       = 8,
   parameter int NREGS    = 4,
   parameter int AW       = $clog2(NREGS),
   parameter int CW       = 8,
   parameter int ALERT_TH = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cfg_we_i,
   input  logic [AW-1:0] cfg_addr_i,
   input  logic [2:0]    cfg_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o,
   output logic          rd_valid_o,
   output logic          err_o,
   output logic [CW-1:0] viol_cnt_o,
   output logic          alert_o
);

   localparam int            c_bit_lock  = 2;
   localparam int            c_bit_re    = 1;
   localparam int            c_bit_we    = 0;
   localparam logic [CW-1:0] c_cnt_max   = '1;
   localparam logic [CW-1:0] c_alert_th  = CW'(ALERT_TH);

   typedef enum logic [0:0] {
      ST_NORMAL   = 1'b0,
      ST_LOCKDOWN = 1'b1
   } state_t;

   state_t        r_state;
   logic [DW-1:0] r_data [NREGS];
   logic [2:0]    r_cfg  [NREGS];
   logic [DW-1:0] r_rd_data;
   logic          r_rd_valid;
   logic          r_err;
   logic [CW-1:0] r_viol_cnt;
   logic          r_alert;

   logic [NREGS-1:0] w_cfg_hit;
   logic [NREGS-1:0] w_wr_hit;
   logic [NREGS-1:0] w_rd_hit;
   logic [2:0]       w_cfg_cur;
   logic [2:0]       w_wr_cur;
   logic [2:0]       w_rd_cur;
   logic [DW-1:0]    w_rd_word;
   logic             w_cfg_grant;
   logic             w_wr_grant;
   logic             w_rd_grant;
   logic             w_deny;
   logic [CW-1:0]    w_cnt_next;

   // One-hot address decode; an address >= NREGS matches no register,
   // which is what makes out-of-range accesses fall through to denial.
   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
         assign w_cfg_hit[gi] = (cfg_addr_i == AW'(gi));
         assign w_wr_hit[gi]  = (wr_addr_i  == AW'(gi));
         assign w_rd_hit[gi]  = (rd_addr_i  == AW'(gi));
      end
   endgenerate

   always_comb begin
      w_cfg_cur = '0;
      w_wr_cur  = '0;
      w_rd_cur  = '0;
      w_rd_word = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (w_cfg_hit[i]) w_cfg_cur = r_cfg[i];
         if (w_wr_hit[i])  w_wr_cur  = r_cfg[i];
         if (w_rd_hit[i]) begin
            w_rd_cur  = r_cfg[i];
            w_rd_word = r_data[i];
         end
      end
   end

   assign w_cfg_grant = cfg_we_i & (|w_cfg_hit) & ~w_cfg_cur[c_bit_lock] & ~r_alert;
   assign w_wr_grant  = wr_en_i  & (|w_wr_hit)  &  w_wr_cur[c_bit_we]    & ~r_alert;
   assign w_rd_grant  = rd_en_i  & (|w_rd_hit)  &  w_rd_cur[c_bit_re]    & ~r_alert;

   assign w_deny = (cfg_we_i & ~w_cfg_grant)
                 | (wr_en_i  & ~w_wr_grant)
                 | (rd_en_i  & ~w_rd_grant);

   assign w_cnt_next = (w_deny && (r_viol_cnt != c_cnt_max)) ? r_viol_cnt + 1'b1
                                                              : r_viol_cnt;

   // Register storage: all permission checks above use pre-edge state, so
   // same-cycle cfg/data updates only become visible on the following cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_data[i] <= '0;
            r_cfg[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (w_cfg_grant && w_cfg_hit[i]) r_cfg[i]  <= cfg_i;
            if (w_wr_grant  && w_wr_hit[i])  r_data[i] <= wr_data_i;
         end
      end
   end

   // Lockdown FSM with its registered outputs; leaving lockdown needs reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_NORMAL;
         r_alert    <= 1'b0;
         r_viol_cnt <= '0;
         r_err      <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_viol_cnt <= w_cnt_next;
         r_err      <= w_deny;
         r_rd_valid <= rd_en_i;
         r_rd_data  <= w_rd_grant ? w_rd_word : '0;
         case (r_state)
            ST_NORMAL: begin
               if (w_cnt_next >= c_alert_th) begin
                  r_state <= ST_LOCKDOWN;
                  r_alert <= 1'b1;
               end
            end
            ST_LOCKDOWN: begin
               r_alert <= 1'b1;
            end
            default: begin
               r_state <= ST_LOCKDOWN;
               r_alert <= 1'b1;
            end
         endcase
      end
   end

   assign rd_data_o  = r_rd_data;
   assign rd_valid_o = r_rd_valid;
   assign err_o      = r_err;
   assign viol_cnt_o = r_viol_cnt;
   assign alert_o    = r_alert;

endmodule
`default_nettype wire

// File: tb/tb_sec_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_sec_reg_bank
// Purpose  : Self-checking bench for sec_reg_bank (NREGS=5, CW=3, ALERT_TH=4).
// Revision : 1.0
// ============================================================================
module tb_sec_reg_bank;

   localparam int DW = 8;
   localparam int NREGS = 5;
   localparam int AW = 3;
   localparam int CW = 3;
   localparam int ALERT_TH = 4;

   logic          clk;
   logic          reset_n;
   logic          cfg_we_i;
   logic [AW-1:0] cfg_addr_i;
   logic [2:0]    cfg_i;
   logic          wr_en_i;
   logic [AW-1:0] wr_addr_i;
   logic [DW-1:0] wr_data_i;
   logic          rd_en_i;
   logic [AW-1:0] rd_addr_i;
   logic [DW-1:0] rd_data_o;
   logic          rd_valid_o;
   logic          err_o;
   logic [CW-1:0] viol_cnt_o;
   logic          alert_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] exp_q[$];

   sec_reg_bank #(
      .DW(DW), .NREGS(NREGS), .AW(AW), .CW(CW), .ALERT_TH(ALERT_TH)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_i(cfg_i),
      .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .err_o(err_o),
      .viol_cnt_o(viol_cnt_o), .alert_o(alert_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-response scoreboard: responses are consumed away from the active edge.
   always @(negedge clk) begin
      if (reset_n && rd_valid_o) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL rd_unexpected: got valid data %0h expected no response", rd_data_o);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (rd_data_o !== e) begin
               n_errors++;
               $display("FAIL rd_data: got %0h expected %0h", rd_data_o, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      cfg_we_i = 0; cfg_addr_i = '0; cfg_i = '0;
      wr_en_i = 0; wr_addr_i = '0; wr_data_i = '0;
      rd_en_i = 0; rd_addr_i = '0;
   endtask

   task automatic do_cycle(input logic c_we, input logic [AW-1:0] c_addr, input logic [2:0] c_val,
                           input logic w_en, input logic [AW-1:0] w_addr, input logic [DW-1:0] w_data,
                           input logic r_en, input logic [AW-1:0] r_addr, input logic [DW-1:0] r_exp);
      cfg_we_i = c_we; cfg_addr_i = c_addr; cfg_i = c_val;
      wr_en_i = w_en; wr_addr_i = w_addr; wr_data_i = w_data;
      rd_en_i = r_en; rd_addr_i = r_addr;
      if (r_en) exp_q.push_back(r_exp);
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic cfg_op(input logic [AW-1:0] a, input logic [2:0] v);
      do_cycle(1, a, v, 0, '0, '0, 0, '0, '0);
   endtask
   task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
      do_cycle(0, '0, '0, 1, a, d, 0, '0, '0);
   endtask
   task automatic rd_op(input logic [AW-1:0] a, input logic [DW-1:0] e);
      do_cycle(0, '0, '0, 0, '0, '0, 1, a, e);
   endtask
   task automatic idle_op();
      do_cycle(0, '0, '0, 0, '0, '0, 0, '0, '0);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      reset_n = 0;
      idle_inputs();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if ({rd_data_o, rd_valid_o, err_o} !== 10'd0) begin
         n_errors++;
         $display("FAIL reset_rd_err: got %0h expected 0", {rd_data_o, rd_valid_o, err_o});
      end
      n_checks++;
      if ({viol_cnt_o, alert_o} !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_cnt_alert: got %0h expected 0", {viol_cnt_o, alert_o});
      end
   endtask

   task automatic test_basic_rw();
      apply_reset();
      cfg_op(1, 3'b011);
      wr_op(1, 8'hA5);
      rd_op(1, 8'hA5);
      n_checks++;
      if (rd_valid_o !== 1'b1 || err_o !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_valid_err: got %b%b expected 10", rd_valid_o, err_o);
      end
      idle_op();
      n_checks++;
      if (rd_valid_o !== 1'b0 || viol_cnt_o !== 3'd0) begin
         n_errors++;
         $display("FAIL basic_idle: got valid %b cnt %0d expected 0 0", rd_valid_o, viol_cnt_o);
      end
   endtask

   task automatic test_lock();
      apply_reset();
      cfg_op(2, 3'b110);
      do_cycle(1, 2, 3'b011, 1, 2, 8'h3C, 0, '0, '0);
      n_checks++;
      if (err_o !== 1'b1 || viol_cnt_o !== 3'd1) begin
         n_errors++;
         $display("FAIL lock_deny: got err %b cnt %0d expected 1 1", err_o, viol_cnt_o);
      end
      idle_op();
      n_checks++;
      if (err_o !== 1'b0 || viol_cnt_o !== 3'd1) begin
         n_errors++;
         $display("FAIL lock_err_pulse: got err %b cnt %0d expected 0 1", err_o, viol_cnt_o);
      end
      rd_op(2, 8'h00);
      wr_op(2, 8'h55);
      n_checks++;
      if (err_o !== 1'b1 || viol_cnt_o !== 3'd2) begin
         n_errors++;
         $display("FAIL lock_cfg_kept: got err %b cnt %0d expected 1 2", err_o, viol_cnt_o);
      end
      rd_op(2, 8'h00);
      idle_op();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL lock_pending: got %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_same_cycle();
      apply_reset();
      do_cycle(1, 0, 3'b001, 1, 0, 8'h11, 0, '0, '0);
      n_checks++;
      if (err_o !== 1'b1 || viol_cnt_o !== 3'd1) begin
         n_errors++;
         $display("FAIL same_cycle_deny: got err %b cnt %0d expected 1 1", err_o, viol_cnt_o);
      end
      wr_op(0, 8'h22);
      n_checks++;
      if (err_o !== 1'b0 || viol_cnt_o !== 3'd1) begin
         n_errors++;
         $display("FAIL same_cycle_write: got err %b cnt %0d expected 0 1", err_o, viol_cnt_o);
      end
      cfg_op(0, 3'b011);
      rd_op(0, 8'h22);
      idle_op();
   endtask

   task automatic test_out_of_range();
      apply_reset();
      cfg_op(4, 3'b011);
      wr_op(4, 8'h77);
      rd_op(4, 8'h77);
      rd_op(7, 8'h00);
      n_checks++;
      if (rd_valid_o !== 1'b1 || err_o !== 1'b1 || viol_cnt_o !== 3'd1) begin
         n_errors++;
         $display("FAIL oor_read: got valid %b err %b cnt %0d expected 1 1 1", rd_valid_o, err_o, viol_cnt_o);
      end
      wr_op(5, 8'hFF);
      cfg_op(6, 3'b011);
      n_checks++;
      if (err_o !== 1'b1 || viol_cnt_o !== 3'd3) begin
         n_errors++;
         $display("FAIL oor_wr_cfg: got err %b cnt %0d expected 1 3", err_o, viol_cnt_o);
      end
      idle_op();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] v;
      apply_reset();
      for (int i = 0; i < NREGS; i++) cfg_op(AW'(i), 3'b011);
      for (int i = 0; i < NREGS; i++) begin
         v = 8'h10 + 8'(i) * 8'h11;
         wr_op(AW'(i), v);
      end
      for (int i = 0; i < NREGS; i++) begin
         v = 8'h10 + 8'(i) * 8'h11;
         rd_op(AW'(i), v);
         n_checks++;
         if (rd_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_valid: got %b expected 1 at read %0d", rd_valid_o, i);
         end
      end
      do_cycle(0, '0, '0, 1, 1, 8'hC3, 1, 1, 8'h21);
      rd_op(1, 8'hC3);
      idle_op();
      n_checks++;
      if (exp_q.size() != 0 || viol_cnt_o !== 3'd0) begin
         n_errors++;
         $display("FAIL b2b_end: got %0d outstanding cnt %0d expected 0 0", exp_q.size(), viol_cnt_o);
      end
   endtask

   task automatic test_alert_saturate();
      logic exp_alert;
      apply_reset();
      cfg_op(1, 3'b011);
      wr_op(1, 8'h5A);
      rd_op(1, 8'h5A);
      for (int k = 1; k <= 4; k++) begin
         wr_op(0, 8'hEE);
         exp_alert = (k >= ALERT_TH);
         n_checks++;
         if (viol_cnt_o !== 3'(k) || alert_o !== exp_alert) begin
            n_errors++;
            $display("FAIL alert_ramp: got cnt %0d alert %b expected %0d %b", viol_cnt_o, alert_o, k, exp_alert);
         end
      end
      rd_op(1, 8'h00);
      n_checks++;
      if (rd_valid_o !== 1'b1 || err_o !== 1'b1 || viol_cnt_o !== 3'd5) begin
         n_errors++;
         $display("FAIL alert_read: got valid %b err %b cnt %0d expected 1 1 5", rd_valid_o, err_o, viol_cnt_o);
      end
      wr_op(1, 8'h99);
      cfg_op(1, 3'b011);
      for (int k = 0; k < 3; k++) wr_op(1, 8'h99);
      n_checks++;
      if (viol_cnt_o !== 3'd7 || alert_o !== 1'b1) begin
         n_errors++;
         $display("FAIL saturate: got cnt %0d alert %b expected 7 1", viol_cnt_o, alert_o);
      end
      // Reset in the middle of a read response.
      rd_en_i = 1; rd_addr_i = 1;
      @(posedge clk); #1;
      rd_en_i = 0;
      n_checks++;
      if (rd_valid_o !== 1'b1) begin
         n_errors++;
         $display("FAIL midread_valid: got %b expected 1", rd_valid_o);
      end
      reset_n = 0;
      #1;
      n_checks++;
      if ({rd_data_o, rd_valid_o, err_o, viol_cnt_o, alert_o} !== 14'd0) begin
         n_errors++;
         $display("FAIL async_reset: got %0h expected 0", {rd_data_o, rd_valid_o, err_o, viol_cnt_o, alert_o});
      end
      exp_q.delete();
      #2 reset_n = 1;
      cfg_op(1, 3'b011);
      rd_op(1, 8'h00);
      n_checks++;
      if (alert_o !== 1'b0 || err_o !== 1'b0 || viol_cnt_o !== 3'd0) begin
         n_errors++;
         $display("FAIL post_reset: got alert %b err %b cnt %0d expected 0 0 0", alert_o, err_o, viol_cnt_o);
      end
      idle_op();
   endtask

   initial begin
      reset_n = 0;
      idle_inputs();
      test_reset();
      test_basic_rw();
      test_lock();
      test_same_cycle();
      test_out_of_range();
      test_back_to_back();
      test_alert_saturate();
      idle_op();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL final_pending: got %0d outstanding expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
